ibex_rf_wr_arbiter: RTL

IBEX_RF_WR_ARBITER -- requirements
Module: ibex_rf_wr_arbiter

---
 rtl/ibex_rf_pkg.sv | 19 +
 rtl/ibex_rr_arb.sv | 21 ++
 rtl/ibex_rf_wr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/ibex_rf_pkg.sv
// rtl/ibex_rf_pkg.sv - shared types and sizing helpers for the register file write path
package ibex_rf_pkg;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } rf_state_e;

    typedef logic [4:0] reg_addr_t;

    function automatic int addr_width(bit rv32e);
        return rv32e ? 4 : 5;
    endfunction

    function automatic int num_words(bit rv32e);
        return 1 << addr_width(rv32e);
    endfunction

endpackage

// File: rtl/ibex_rr_arb.sv
// rtl/ibex_rr_arb.sv - round-robin one-hot selector starting its search at ptr
module ibex_rr_arb #(
    parameter int NumReq = 3,
    parameter int PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [PtrW-1:0]   ptr,
    output logic [NumReq-1:0] gnt
);

    logic [NumReq-1:0] rot;
    logic [NumReq-1:0] first;

    // Rotate so the requester at ptr sits in bit 0, keep the lowest set bit, rotate back
    always_comb begin
        rot   = NumReq'({req, req} >> ptr);
        first = rot & (~rot + NumReq'(1));
        gnt   = NumReq'(({first, first} << ptr) >> NumReq);
    end

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// rtl/ibex_rf_wr_arbiter.sv - register file write arbiter with zero-init sweep
module ibex_rf_wr_arbiter
    import ibex_rf_pkg::*;
#(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32,
    parameter int NumReq    = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_req_i,
    input  logic [NumReq-1:0]           req_i,
    input  logic [NumReq*5-1:0]         addr_i,
    input  logic [NumReq*DataWidth-1:0] wdata_i,
    output logic [NumReq-1:0]           gnt_o,
    output logic                        init_done_o,
    output logic                        rf_we_o,
    output logic [4:0]                  rf_waddr_o,
    output logic [DataWidth-1:0]        rf_wdata_o
);

    localparam int        NumWords = num_words(RV32E);
    localparam int        PtrW     = $clog2(NumReq);
    localparam reg_addr_t LastAddr = reg_addr_t'(NumWords - 1);
    localparam reg_addr_t AddrMask = reg_addr_t'(NumWords - 1);

    rf_state_e             state_q, state_d;
    reg_addr_t             cnt_q, cnt_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic                  we_d;
    reg_addr_t             waddr_d;
    logic [DataWidth-1:0]  wdata_d;
    logic                  arb_en;
    logic [NumReq-1:0]     gnt;
    reg_addr_t             sel_addr;

    // Grants only exist in ARB, out of reset, and not while a clear is being taken
    assign arb_en = (state_q == ARB) && !clear_req_i && rst_ni;

    ibex_rr_arb #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_rr_arb (
        .req (req_i & {NumReq{arb_en}}),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign gnt_o       = gnt;
    assign init_done_o = (state_q == ARB);

    // Next state, sweep counter, pointer and the write to be registered this edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        we_d     = 1'b0;
        waddr_d  = rf_waddr_o;
        wdata_d  = rf_wdata_o;
        sel_addr = '0;
        case (state_q)
            INIT: begin
                if (clear_req_i) begin
                    cnt_d = reg_addr_t'(1);
                end else begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = '0;
                    if (cnt_q == LastAddr) begin
                        state_d = ARB;
                        cnt_d   = reg_addr_t'(1);
                    end else begin
                        cnt_d = cnt_q + reg_addr_t'(1);
                    end
                end
            end
            ARB: begin
                if (clear_req_i) begin
                    state_d = INIT;
                    cnt_d   = reg_addr_t'(1);
                end else begin
                    for (int k = 0; k < NumReq; k++) begin
                        if (gnt[k]) begin
                            sel_addr = addr_i[k*5 +: 5] & AddrMask;
                            ptr_d    = PtrW'((k + 1) % NumReq);
                            we_d     = (sel_addr != '0);
                            waddr_d  = sel_addr;
                            wdata_d  = wdata_i[k*DataWidth +: DataWidth];
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State and registered write port; reset discards any pending write
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            cnt_q      <= reg_addr_t'(1);
            ptr_q      <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            rf_we_o    <= we_d;
            rf_waddr_o <= waddr_d;
            rf_wdata_o <= wdata_d;
        end
    end

endmodule
